routed_packet_hub: RTL and testbench



---
 rtl/routed_packet_hub.sv | 217 +++++++++++++++++++++
 tb/tb_routed_packet_hub.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/routed_packet_hub.sv
`timescale 1ns/1ps
// routed_packet_hub
// Packet hub between the SPI minion adapter and the on-chip endpoints.
// Downstream packets {addr, payload} sit in a one-entry ingress buffer and are
// steered to one endpoint, dropped (port disabled), applied as a control write
// (addr 0, payload MSB set) or turned into a loopback reply (addr 0, MSB clear).
// Upstream words from enabled endpoints plus the loopback entry are round-robin
// arbitrated, tagged with their source address and queued in a 2-entry FIFO.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   recv_val/rdy/msg       downstream packet from the adapter {addr, payload}
//   src_val/rdy/msg        per-endpoint downstream handshake (bit 0 unused)
//   snk_val/rdy/msg        per-endpoint upstream handshake (bit 0 unused)
//   send_val/rdy/msg       upstream word to the adapter {source addr, payload}
//   port_en                current enable mask (bit 0 always 1)
//   drop_count             saturating count of dropped downstream packets
module routed_packet_hub #(
    parameter  int BIT_WIDTH = 32,
    parameter  int N_PORTS   = 16,
    localparam int ADDR_BITS = $clog2(N_PORTS),
    localparam int MSG_W     = BIT_WIDTH + ADDR_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recv_val,
    output logic                         recv_rdy,
    input  logic [MSG_W-1:0]             recv_msg,
    output logic [N_PORTS-1:0]           src_val,
    input  logic [N_PORTS-1:0]           src_rdy,
    output logic [N_PORTS*BIT_WIDTH-1:0] src_msg,
    input  logic [N_PORTS-1:0]           snk_val,
    output logic [N_PORTS-1:0]           snk_rdy,
    input  logic [N_PORTS*BIT_WIDTH-1:0] snk_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [MSG_W-1:0]             send_msg,
    output logic [N_PORTS-1:0]           port_en,
    output logic [15:0]                  drop_count
);

    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [N_PORTS-1:0]   EN_BIT0   = {{(N_PORTS-1){1'b0}}, 1'b1};

    logic                   ing_full_q, ing_full_d;
    logic                   ing_drop_q, ing_drop_d;
    logic [ADDR_BITS-1:0]   ing_addr_q, ing_addr_d;
    logic [BIT_WIDTH-1:0]   ing_data_q, ing_data_d;
    logic [N_PORTS-1:0]     port_en_q, port_en_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [MSG_W-1:0]       fifo_q [2];
    logic [MSG_W-1:0]       fifo_d [2];
    logic                   wr_q, wr_d, rd_q, rd_d;
    logic [1:0]             cnt_q, cnt_d;

    logic                   ing_ctrl_s, ing_loop_s, ing_route_s, ing_dropping_s;
    logic                   ing_leave_s, recv_hs_s;
    logic [N_PORTS-1:0]     req_s;
    logic                   found_s, hit_s, eg_full_s, eg_hs_s, deq_s;
    logic [ADDR_BITS-1:0]   winner_s;
    logic [BIT_WIDTH-1:0]   snk_word_s;
    logic [N_PORTS-1:0]     src_val_s, snk_rdy_s;
    logic [ADDR_BITS-1:0]   recv_addr_s;

    assign recv_addr_s = recv_msg[MSG_W-1 -: ADDR_BITS];

    // Classify the buffered ingress entry; the drop decision was latched at capture.
    always_comb begin
        ing_ctrl_s     = ing_full_q && (ing_addr_q == ADDR_ZERO) && ing_data_q[BIT_WIDTH-1];
        ing_loop_s     = ing_full_q && (ing_addr_q == ADDR_ZERO) && !ing_data_q[BIT_WIDTH-1];
        ing_route_s    = ing_full_q && (ing_addr_q != ADDR_ZERO) && !ing_drop_q;
        ing_dropping_s = ing_full_q && ing_drop_q;
    end

    // Round-robin search starting at ptr; requester 0 is the loopback entry.
    always_comb begin
        req_s    = snk_val & port_en_q;
        req_s[0] = ing_loop_s;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        winner_s = ptr_q;
        for (int k = 0; k < N_PORTS; k++) begin
            hit_s    = !found_s && req_s[ptr_q + ADDR_BITS'(k)];
            winner_s = hit_s ? (ptr_q + ADDR_BITS'(k)) : winner_s;
            found_s  = found_s || hit_s;
        end
    end

    // Select the upstream payload of the winning endpoint.
    always_comb begin
        snk_word_s = {BIT_WIDTH{1'b0}};
        for (int i = 0; i < N_PORTS; i++) begin
            snk_word_s = (winner_s == ADDR_BITS'(i)) ? snk_msg[i*BIT_WIDTH +: BIT_WIDTH] : snk_word_s;
        end
    end

    // Handshake decisions; a full FIFO still takes a word when it dequeues this cycle.
    always_comb begin
        eg_full_s   = (cnt_q == 2'd2) && !send_rdy;
        eg_hs_s     = found_s && !eg_full_s && !reset;
        deq_s       = (cnt_q != 2'd0) && send_rdy;
        ing_leave_s = ing_ctrl_s || ing_dropping_s ||
                      (ing_loop_s && eg_hs_s && (winner_s == ADDR_ZERO)) ||
                      (ing_route_s && src_rdy[ing_addr_q]);
        recv_rdy    = !reset && (!ing_full_q || ing_leave_s);
        recv_hs_s   = recv_val && recv_rdy;
    end

    // Per-port valid/ready vectors.
    always_comb begin
        src_val_s = {N_PORTS{1'b0}};
        snk_rdy_s = {N_PORTS{1'b0}};
        if (ing_route_s) begin
            src_val_s[ing_addr_q] = 1'b1;
        end else begin
            src_val_s = {N_PORTS{1'b0}};
        end
        if (eg_hs_s && (winner_s != ADDR_ZERO)) begin
            snk_rdy_s[winner_s] = 1'b1;
        end else begin
            snk_rdy_s = {N_PORTS{1'b0}};
        end
    end

    assign src_val    = src_val_s;
    assign snk_rdy    = snk_rdy_s;
    // Every slice carries the payload; only the addressed src_val qualifies it.
    assign src_msg    = {N_PORTS{ing_data_q}};
    assign send_val   = (cnt_q != 2'd0);
    assign send_msg   = fifo_q[rd_q];
    assign port_en    = port_en_q;
    assign drop_count = drop_count_q;

    // Next-state for mask, drop counter and ingress buffer.
    always_comb begin
        port_en_d    = port_en_q;
        drop_count_d = drop_count_q;
        ing_full_d   = ing_full_q;
        ing_drop_d   = ing_drop_q;
        ing_addr_d   = ing_addr_q;
        ing_data_d   = ing_data_q;
        if (ing_ctrl_s) begin
            port_en_d = ing_data_q[N_PORTS-1:0] | EN_BIT0;
        end else begin
            port_en_d = port_en_q;
        end
        if (ing_dropping_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
        // Capture checks the mask as it will be after this edge, so a control
        // write leaving now already applies to the packet arriving behind it.
        if (recv_hs_s) begin
            ing_full_d = 1'b1;
            ing_addr_d = recv_addr_s;
            ing_data_d = recv_msg[BIT_WIDTH-1:0];
            ing_drop_d = (recv_addr_s != ADDR_ZERO) && !port_en_d[recv_addr_s];
        end else if (ing_leave_s) begin
            ing_full_d = 1'b0;
        end else begin
            ing_full_d = ing_full_q;
        end
    end

    // Next-state for arbiter pointer and egress FIFO.
    always_comb begin
        ptr_d  = eg_hs_s ? (winner_s + ADDR_ONE) : ptr_q;
        fifo_d = fifo_q;
        if (eg_hs_s) begin
            fifo_d[wr_q] = {winner_s, (winner_s == ADDR_ZERO) ? ing_data_q : snk_word_s};
        end else begin
            fifo_d = fifo_q;
        end
        wr_d = wr_q ^ eg_hs_s;
        rd_d = rd_q ^ deq_s;
        case ({eg_hs_s, deq_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ing_full_q   <= 1'b0;
            ing_drop_q   <= 1'b0;
            ing_addr_q   <= ADDR_ZERO;
            ing_data_q   <= {BIT_WIDTH{1'b0}};
            port_en_q    <= {N_PORTS{1'b1}};
            drop_count_q <= 16'd0;
            ptr_q        <= ADDR_ZERO;
            fifo_q[0]    <= {MSG_W{1'b0}};
            fifo_q[1]    <= {MSG_W{1'b0}};
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            cnt_q        <= 2'd0;
        end else begin
            ing_full_q   <= ing_full_d;
            ing_drop_q   <= ing_drop_d;
            ing_addr_q   <= ing_addr_d;
            ing_data_q   <= ing_data_d;
            port_en_q    <= port_en_d;
            drop_count_q <= drop_count_d;
            ptr_q        <= ptr_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_routed_packet_hub.sv
`timescale 1ns/1ps
// Self-checking bench for routed_packet_hub: directed table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_routed_packet_hub;
    localparam int BW = 32;
    localparam int NP = 16;
    localparam int AW = 4;
    localparam int MW = BW + AW;

    logic clk = 1'b0;
    logic reset;
    logic recv_val, recv_rdy;
    logic [MW-1:0] recv_msg;
    logic [NP-1:0] src_val, src_rdy;
    logic [NP*BW-1:0] src_msg;
    logic [NP-1:0] snk_val, snk_rdy;
    logic [NP*BW-1:0] snk_msg;
    logic send_val, send_rdy;
    logic [MW-1:0] send_msg;
    logic [NP-1:0] port_en;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    routed_packet_hub #(.BIT_WIDTH(BW), .N_PORTS(NP)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .src_val(src_val), .src_rdy(src_rdy), .src_msg(src_msg),
        .snk_val(snk_val), .snk_rdy(snk_rdy), .snk_msg(snk_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .port_en(port_en), .drop_count(drop_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [NP-1:0] exp_src;
        logic          exp_send;
        logic [MW-1:0] exp_msg;
        logic [NP-1:0] exp_en;
        logic [15:0]   exp_drop;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] src_slice(input int i);
        return src_msg[i*BW +: BW];
    endfunction

    task automatic idle();
        recv_val = 1'b0;
        recv_msg = '0;
        src_rdy  = '1;
        snk_val  = '0;
        snk_msg  = '0;
        send_rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // reference model state
    logic          m_full, m_drop;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_data;
    logic [NP-1:0] m_en;
    int            m_cnt, m_ptr;
    logic [MW-1:0] m_q [$];

    task automatic random_run(input int cycles);
        logic [NP-1:0] req, exp_src, exp_snk, new_en;
        logic found, can_enq, eg_hs, route, leave, exp_rrdy;
        int win, j;
        m_full = 1'b0; m_drop = 1'b0; m_addr = '0; m_data = '0;
        m_en = '1; m_cnt = 0; m_ptr = 0; m_q.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            recv_val = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    recv_msg = {4'd0, 1'b1, 15'($urandom), 16'hFFFF ^ (16'h1 << $urandom_range(0, 15))};
                else
                    recv_msg = {4'd0, 1'b0, 31'($urandom)};
            end else begin
                recv_msg = {AW'($urandom_range(1, NP - 1)), 32'($urandom)};
            end
            src_rdy  = NP'($urandom);
            snk_val  = NP'($urandom) & NP'($urandom);
            for (int i = 0; i < NP; i++) snk_msg[i*BW +: BW] = 32'($urandom);
            send_rdy = ($urandom_range(0, 3) != 0);
            #1;
            req    = snk_val & m_en;
            req[0] = m_full && (m_addr == 0) && !m_data[BW-1];
            found  = 1'b0;
            win    = 0;
            for (int k = 0; k < NP; k++) begin
                j = (m_ptr + k) % NP;
                if (!found && req[j]) begin found = 1'b1; win = j; end
            end
            can_enq  = (m_q.size() < 2) || send_rdy;
            eg_hs    = found && can_enq;
            exp_snk  = (eg_hs && win != 0) ? (NP'(1) << win) : '0;
            route    = m_full && (m_addr != 0) && !m_drop;
            exp_src  = route ? (NP'(1) << m_addr) : '0;
            leave    = m_full && (m_drop || ((m_addr == 0) && m_data[BW-1]) ||
                       ((m_addr == 0) && !m_data[BW-1] && eg_hs && win == 0) ||
                       (route && src_rdy[m_addr]));
            exp_rrdy = !m_full || leave;
            check("rnd recv_rdy", 64'(recv_rdy), 64'(exp_rrdy));
            check("rnd src_val", 64'(src_val), 64'(exp_src));
            if (route) check("rnd src_msg", 64'(src_slice(int'(m_addr))), 64'(m_data));
            check("rnd snk_rdy", 64'(snk_rdy), 64'(exp_snk));
            check("rnd send_val", 64'(send_val), 64'(m_q.size() > 0));
            if (m_q.size() > 0) check("rnd send_msg", 64'(send_msg), 64'(m_q[0]));
            check("rnd port_en", 64'(port_en), 64'(m_en));
            check("rnd drop_count", 64'(drop_count), 64'(m_cnt));
            @(posedge clk);
            if (m_q.size() > 0 && send_rdy) void'(m_q.pop_front());
            if (eg_hs) begin
                m_q.push_back({AW'(win), (win == 0) ? m_data : snk_msg[win*BW +: BW]});
                m_ptr = (win + 1) % NP;
            end
            new_en = m_en;
            if (m_full && m_addr == 0 && m_data[BW-1]) new_en = m_data[NP-1:0] | NP'(1);
            if (m_full && m_drop && m_cnt < 65535) m_cnt++;
            if (leave) m_full = 1'b0;
            if (recv_val && exp_rrdy) begin
                m_full = 1'b1;
                m_addr = recv_msg[MW-1 -: AW];
                m_data = recv_msg[BW-1:0];
                m_drop = (m_addr != 0) && !new_en[m_addr];
            end
            m_en = new_en;
        end
        @(negedge clk);
        idle();
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'd5,  32'hDEADBEEF, 16'h0020, 1'b0, 36'h0, 16'hFFFF, 16'd0};
        tbl[1] = '{4'd3,  32'h00000003, 16'h0008, 1'b0, 36'h0, 16'hFFFF, 16'd0};
        tbl[2] = '{4'd15, 32'hFFFFFFFF, 16'h8000, 1'b0, 36'h0, 16'hFFFF, 16'd0};
        tbl[3] = '{4'd0,  32'h8000FFDF, 16'h0000, 1'b0, 36'h0, 16'hFFDF, 16'd0};
        tbl[4] = '{4'd5,  32'hCAFEF00D, 16'h0000, 1'b0, 36'h0, 16'hFFDF, 16'd1};
        tbl[5] = '{4'd0,  32'h00001234, 16'h0000, 1'b1, {4'd0, 32'h00001234}, 16'hFFDF, 16'd1};
        tbl[6] = '{4'd0,  32'h8000FFFE, 16'h0000, 1'b0, 36'h0, 16'hFFFF, 16'd1};
        tbl[7] = '{4'd5,  32'h00000055, 16'h0020, 1'b0, 36'h0, 16'hFFFF, 16'd1};

        // reset behaviour, including gating while reset is high
        reset = 1'b1;
        idle();
        snk_val = 16'h0004;
        repeat (2) @(negedge clk);
        check("in-reset recv_rdy", 64'(recv_rdy), 64'd0);
        check("in-reset snk_rdy", 64'(snk_rdy), 64'd0);
        reset = 1'b0;
        snk_val = '0;
        #1;
        check("reset recv_rdy", 64'(recv_rdy), 64'd1);
        check("reset send_val", 64'(send_val), 64'd0);
        check("reset src_val", 64'(src_val), 64'd0);
        check("reset port_en", 64'(port_en), 64'hFFFF);
        check("reset drop_count", 64'(drop_count), 64'd0);

        // directed table: one packet each, endpoints always ready
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            recv_val = 1'b1;
            recv_msg = {tbl[v].addr, tbl[v].data};
            #1 check("tbl recv_rdy", 64'(recv_rdy), 64'd1);
            @(posedge clk);
            #1 recv_val = 1'b0;
            @(negedge clk);
            check("tbl src_val", 64'(src_val), 64'(tbl[v].exp_src));
            check("tbl early send_val", 64'(send_val), 64'd0);
            if (tbl[v].exp_src != 0) check("tbl src_msg", 64'(src_slice(int'(tbl[v].addr))), 64'(tbl[v].data));
            @(posedge clk);
            @(negedge clk);
            check("tbl src_val cleared", 64'(src_val), 64'd0);
            check("tbl send_val", 64'(send_val), 64'(tbl[v].exp_send));
            if (tbl[v].exp_send) check("tbl send_msg", 64'(send_msg), 64'(tbl[v].exp_msg));
            check("tbl port_en", 64'(port_en), 64'(tbl[v].exp_en));
            check("tbl drop_count", 64'(drop_count), 64'(tbl[v].exp_drop));
            @(posedge clk);
        end

        // endpoint stall: message stable, ingress back-pressured, then bubble-free refill
        @(negedge clk);
        src_rdy[5] = 1'b0;
        recv_val = 1'b1;
        recv_msg = {4'd5, 32'hA5A50001};
        @(posedge clk);
        #1 recv_msg = {4'd6, 32'h00000666};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall src_val", 64'(src_val), 64'h0020);
            check("stall src_msg", 64'(src_slice(5)), 64'hA5A50001);
            check("stall recv_rdy", 64'(recv_rdy), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        src_rdy[5] = 1'b1;
        #1 check("unstall recv_rdy", 64'(recv_rdy), 64'd1);
        @(posedge clk);
        #1 recv_val = 1'b0;
        @(negedge clk);
        check("refill src_val", 64'(src_val), 64'h0040);
        check("refill src_msg", 64'(src_slice(6)), 64'h00000666);
        @(posedge clk);

        // fairness among three endpoints, then FIFO fill with send_rdy low
        do_reset();
        snk_val = 16'h000E;
        for (int i = 1; i <= 3; i++) snk_msg[i*BW +: BW] = BW'(32'h100 + i);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr send_val", 64'(send_val), 64'd1);
            check("rr send_msg", 64'(send_msg), 64'({AW'(k % 3 + 1), BW'(32'h100 + k % 3 + 1)}));
        end
        send_rdy = 1'b0;
        #1 check("rr snk_rdy wrap", 64'(snk_rdy), 64'h0002);
        @(posedge clk);
        @(negedge clk);
        check("full snk_rdy", 64'(snk_rdy), 64'd0);
        check("full head", 64'(send_msg), 64'({4'd3, 32'h00000103}));
        @(posedge clk);
        @(negedge clk);
        check("full snk_rdy hold", 64'(snk_rdy), 64'd0);
        check("full send_val", 64'(send_val), 64'd1);
        idle();
        repeat (3) @(posedge clk);

        // asynchronous reset between edges with traffic in flight
        @(negedge clk);
        src_rdy[7] = 1'b0;
        recv_val = 1'b1;
        recv_msg = {4'd7, 32'h00007777};
        snk_val[2] = 1'b1;
        snk_msg[2*BW +: BW] = 32'h00000222;
        send_rdy = 1'b0;
        @(posedge clk);
        #1 recv_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre-reset src_val", 64'(src_val), 64'h0080);
        check("pre-reset send_val", 64'(send_val), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async src_val", 64'(src_val), 64'd0);
        check("async send_val", 64'(send_val), 64'd0);
        check("async recv_rdy", 64'(recv_rdy), 64'd0);
        check("async snk_rdy", 64'(snk_rdy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        recv_val = 1'b1;
        recv_msg = {4'd9, 32'h00009999};
        @(posedge clk);
        #1 recv_val = 1'b0;
        @(negedge clk);
        check("post-reset src_val", 64'(src_val), 64'h0200);
        check("post-reset src_msg", 64'(src_slice(9)), 64'h00009999);
        check("post-reset drop_count", 64'(drop_count), 64'd0);
        check("post-reset send_val", 64'(send_val), 64'd0);
        @(posedge clk);

        // randomized traffic against the reference model
        do_reset();
        random_run(400);

        // drop counter accuracy and saturation
        do_reset();
        recv_val = 1'b1;
        recv_msg = {4'd0, 32'h8000FFDF};
        @(posedge clk);
        #1 recv_msg = {4'd5, 32'h0BADF00D};
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("drop burst count", 64'(drop_count), 64'd99);
        check("drop burst recv_rdy", 64'(recv_rdy), 64'd1);
        check("drop burst src_val", 64'(src_val), 64'd0);
        repeat (65500) @(posedge clk);
        @(negedge clk);
        recv_val = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("drop saturate", 64'(drop_count), 64'hFFFF);
        check("drop port_en", 64'(port_en), 64'hFFDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
